dw_line_buffer: RTL and testbench
=================================

DW_LINE_BUFFER -- requirements
Module: dw_line_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning pixel width (matches depthwise input_feature).
REQ-002 SHALL have parameter IMG_W, default 32, meaning pixels per row (>= 3).
REQ-003 SHALL have parameter IMG_H, default 32, meaning rows per frame (>= 3).
REQ-004 SHALL have port clk  input  1  meaning single clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  meaning asynchronous, active-low reset.
REQ-006 SHALL have port in_valid  input  1  meaning in_data valid.
REQ-007 SHALL have port in_ready  output  1  meaning block accepts in_data this cycle.
REQ-008 SHALL have port in_data  input  DATA_W  meaning raster-order pixel, row-major.
REQ-009 SHALL have port out_valid  output  1  meaning out_window holds a 3x3 window.
REQ-010 SHALL have port out_ready  input  1  meaning downstream depthwise stage consumes the window.
REQ-011 SHALL have port out_window  output  9*DATA_W  meaning tap k=r*3+c at bits [k*DATA_W +: DATA_W]; r=0 oldest row, c=0 leftmost column.
REQ-012 SHALL have port frame_done  output  1  meaning one-cycle pulse when the last window of a frame is consumed.

Function
REQ-013 SHALL accept a pixel only on in_valid && in_ready; SHALL accept a window transfer only on out_valid && out_ready.
REQ-014 SHALL drive in_ready = (state != FLUSH) && (!out_valid || out_ready).
REQ-015 SHALL keep col (0..IMG_W-1) and row (0..IMG_H-1) counters advanced per accepted pixel; col wraps to 0 and increments row.
REQ-016 SHALL store the two previous rows in two line FIFOs of depth IMG_W, advanced only on accepted pixels.
REQ-017 SHALL keep a 3x3 shift window fed by {line1 out, line0 out, in_data}, shifted left one column per accepted pixel.
REQ-018 SHALL produce a window only for accepted pixel (row y, col x) with y >= 2 and x >= 2, covering rows y-2..y, cols x-2..x; no padding; (IMG_H-2)*(IMG_W-2) windows per frame.
REQ-019 SHALL assert out_valid with the window on the cycle after the completing pixel is accepted (latency 1); window and out_valid held stable until consumed.
REQ-020 SHALL, when a window is consumed and a new completing pixel is accepted in the same cycle, load the new window and keep out_valid high.
REQ-021 SHALL clear out_valid after consumption when no new window is loaded that cycle.
REQ-022 SHALL implement states FILL (row < 2, or row >= 2 and col < 2), RUN (windows being produced), FLUSH (last frame pixel accepted, final window not yet consumed).
REQ-023 SHALL transition FILL->RUN on acceptance of the first window-completing pixel; RUN->FILL on row wrap within frame only at col wrap when x < 2 of next row follows (state tracks col < 2); RUN->FLUSH on acceptance of pixel (IMG_H-1, IMG_W-1).
REQ-024 SHALL transition FLUSH->FILL and pulse frame_done for one cycle when the final window is consumed; row and col return to 0.
REQ-025 SHALL hold in_ready low throughout FLUSH; pixels of the next frame wait.
REQ-026 SHALL pass pixel data unmodified (no arithmetic, no width change).

Reset
REQ-027 SHALL, on rst low, asynchronously clear out_valid, frame_done, out_window, row, col to 0 and set state FILL; in_ready reflects FILL with out_valid 0.
REQ-028 SHALL discard a frame in progress on mid-operation reset; line FIFO contents need not be cleared since no window is emitted until refilled.

Structure
REQ-029 SHALL place DATA_W default, kernel size 3, and the FILL/RUN/FLUSH state encoding in shared package dw_pkg.
REQ-030 SHALL instantiate sub-module dw_line_fifo (depth IMG_W, width DATA_W, circular buffer with shift enable) twice.

Verification (IMG_W=4, IMG_H=4, out_ready=1 unless stated)
REQ-031 Pixels 0..15 continuous -> 4 windows; first {0,1,2,4,5,6,8,9,10} one cycle after pixel 10 accepted; last {5,6,7,9,10,11,13,14,15}.
REQ-032 out_ready low 5 cycles while window {0,1,2,4,5,6,8,9,10} valid -> window held stable, in_ready low, no pixel lost; next window {1,2,3,5,6,7,9,10,11}.
REQ-033 Random in_valid gaps across frame -> identical window sequence to REQ-031.
REQ-034 Two back-to-back frames -> frame_done pulses once per frame, one cycle, on last window consumption; in_ready low during FLUSH; second frame windows match first.
REQ-035 rst low after pixel 9 of frame, then pixels 0..15 -> no window before pixel 10 of new frame; outputs 0 during reset; sequence matches REQ-031.
REQ-036 out_ready toggling each cycle in RUN -> simultaneous consume/load keeps out_valid high without bubble or duplicate window.

Source files
------------

// File: rtl/dw_pkg.sv
// Shared constants and state encoding for the depthwise line-buffer front end.
package dw_pkg;

  localparam int DW_DATA_W = 8;
  localparam int KSIZE     = 3;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } dw_state_e;

endpackage

// File: rtl/dw_line_fifo.sv
// Single-row delay line: a circular buffer whose output is the pixel written DEPTH shifts ago.
module dw_line_fifo #(
  parameter int DEPTH  = 32,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
    end
  end

  // Storage is never reset: stale rows are overwritten before any window uses them.
  always_ff @(posedge clk) begin
    if (en) begin
      mem[ptr] <= din;
    end
  end

  assign dout = mem[ptr];

endmodule

// File: rtl/dw_line_buffer.sv
// Raster-to-3x3-window converter feeding the depthwise convolution stage.
module dw_line_buffer
  import dw_pkg::*;
#(
  parameter int DATA_W = DW_DATA_W,
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [9*DATA_W-1:0] out_window,
  output logic                frame_done
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  dw_state_e state, state_nxt;

  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic              accept, consume, completing, col_wrap, last_px;
  logic [DATA_W-1:0] line0_q, line1_q;
  logic [DATA_W-1:0] win [KSIZE][KSIZE];

  assign accept     = in_valid && in_ready;
  assign consume    = out_valid && out_ready;
  assign col_wrap   = (col == COL_LAST);
  assign last_px    = col_wrap && (row == ROW_LAST);
  assign completing = accept && (row >= RW'(2)) && (col >= CW'(2));

  // line0 delays the current row by one row, line1 chains it by a second row.
  dw_line_fifo #(.DEPTH(IMG_W), .DATA_W(DATA_W)) u_line0 (
    .clk  (clk),
    .rst  (rst),
    .en   (accept),
    .din  (in_data),
    .dout (line0_q)
  );

  dw_line_fifo #(.DEPTH(IMG_W), .DATA_W(DATA_W)) u_line1 (
    .clk  (clk),
    .rst  (rst),
    .en   (accept),
    .din  (line0_q),
    .dout (line1_q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      col <= col_wrap ? '0 : col + 1'b1;
      if (col_wrap) begin
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end
    end
  end

  // Window shifts only on accepted pixels, so a pending window stays frozen while stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < KSIZE; r++) begin
        for (int c = 0; c < KSIZE; c++) begin
          win[r][c] <= '0;
        end
      end
    end else if (accept) begin
      for (int r = 0; r < KSIZE; r++) begin
        for (int c = 0; c < KSIZE - 1; c++) begin
          win[r][c] <= win[r][c+1];
        end
      end
      win[0][KSIZE-1] <= line1_q;
      win[1][KSIZE-1] <= line0_q;
      win[2][KSIZE-1] <= in_data;
    end
  end

  always_comb begin
    out_window = '0;
    for (int r = 0; r < KSIZE; r++) begin
      for (int c = 0; c < KSIZE; c++) begin
        out_window[(r*KSIZE+c)*DATA_W +: DATA_W] = win[r][c];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      if (completing) begin
        out_valid <= 1'b1;
      end else if (consume) begin
        out_valid <= 1'b0;
      end
      frame_done <= (state == FLUSH) && consume;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL: begin
        if (completing && last_px) begin
          state_nxt = FLUSH;
        end else if (completing) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (accept && last_px) begin
          state_nxt = FLUSH;
        end else if (accept && col_wrap) begin
          state_nxt = FILL;
        end
      end
      FLUSH: begin
        if (consume) begin
          state_nxt = FILL;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  always_comb begin
    in_ready = (state != FLUSH) && (!out_valid || out_ready);
  end

endmodule

// File: tb/tb_dw_line_buffer.sv
// Scoreboard bench for dw_line_buffer on a 4x4 frame.
module tb_dw_line_buffer;
  localparam int DATA_W = 8;
  localparam int IMG_W  = 4;
  localparam int IMG_H  = 4;
  localparam int NPIX   = IMG_W * IMG_H;
  localparam int WW     = 9 * DATA_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [WW-1:0]     out_window;
  logic              frame_done;

  dw_line_buffer #(.DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_window (out_window),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int            n_chk = 0;
  int            n_err = 0;
  logic [WW-1:0] q [$];
  logic [7:0]    fr [NPIX];
  int            p = 0;
  bit            flush = 0;
  bit            fd_pending = 0;
  int            cyc = 0;
  int            or_mode = 0;
  int            stall_left = 0;
  int            fd_count = 0;
  bit            last_acc = 0;

  task automatic check_eq(input string tag, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, act, exp);
    end
  endtask

  function automatic logic [WW-1:0] exp_win(input int row, input int col);
    logic [WW-1:0] w;
    w = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        w[(r*3+c)*DATA_W +: DATA_W] = fr[(row-2+r)*IMG_W + (col-2+c)];
      end
    end
    return w;
  endfunction

  // One clock: drive out_ready, check just before the edge, update model, advance.
  task automatic step();
    logic          exp_ir, exp_ov, acc, cons, new_fd;
    logic [WW-1:0] w;
    int            row, col;
    case (or_mode)
      1: out_ready = cyc[0];
      2: begin
        out_ready = !(q.size() > 0 && stall_left > 0);
        if (!out_ready) stall_left--;
      end
      default: out_ready = 1'b1;
    endcase
    #1;
    exp_ov = q.size() > 0;
    exp_ir = !flush && (!exp_ov || out_ready);
    check_eq("ready_valid", {in_ready, out_valid}, {exp_ir, exp_ov});
    check_eq("frame_done", frame_done, fd_pending);
    if (frame_done) fd_count++;
    if (!out_ready && exp_ov) check_eq("hold", out_window, q[0]);
    acc    = in_valid && in_ready;
    cons   = out_valid && out_ready;
    new_fd = 1'b0;
    if (cons && q.size() > 0) begin
      w = q.pop_front();
      check_eq("window", out_window, w);
      if (flush && q.size() == 0) begin
        flush  = 0;
        new_fd = 1'b1;
      end
    end
    if (acc) begin
      fr[p] = in_data;
      row = p / IMG_W;
      col = p % IMG_W;
      if (row >= 2 && col >= 2) q.push_back(exp_win(row, col));
      if (p == NPIX - 1) begin
        flush = 1;
        p = 0;
      end else begin
        p++;
      end
    end
    last_acc   = acc;
    fd_pending = new_fd;
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_pixel(input logic [7:0] v, input bit gap);
    int n;
    n = 0;
    last_acc = 0;
    while (!last_acc && n < 200) begin
      in_valid = gap ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data  = v;
      step();
      n++;
    end
    in_valid = 1'b0;
    check_eq("accept", last_acc, 1);
  endtask

  task automatic send_frame(input bit gap, input bit rnd);
    for (int i = 0; i < NPIX; i++) begin
      send_pixel(rnd ? 8'($urandom_range(0, 255)) : 8'(i), gap);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    while ((q.size() > 0 || flush || fd_pending) && n < 100) begin
      step();
      n++;
    end
    check_eq("drain", {q.size() > 0, flush}, 0);
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_frame_done", frame_done, 0);
    check_eq("rst_out_window", out_window, 0);
    check_eq("rst_in_ready", in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout n_err=%0d n_chk=%0d", n_err, n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst = 1'b1;

    // Continuous frame, sink always ready.
    or_mode = 0;
    send_frame(0, 0);
    drain();

    // Sink stalls five cycles on the first window.
    or_mode = 2;
    stall_left = 5;
    send_frame(0, 0);
    drain();

    // Random input gaps.
    or_mode = 0;
    send_frame(1, 0);
    drain();

    // Two frames back to back; the second waits out the flush of the first.
    send_frame(0, 0);
    send_frame(0, 0);
    drain();

    // Sink ready toggling every cycle.
    or_mode = 1;
    send_frame(0, 0);
    drain();

    // Abort a frame after pixel 9, then restart cleanly.
    or_mode = 0;
    for (int i = 0; i < 10; i++) send_pixel(8'(i), 0);
    rst = 1'b0;
    #1;
    check_reset_outputs();
    @(negedge clk);
    #1;
    check_reset_outputs();
    rst = 1'b1;
    q.delete();
    flush = 0;
    fd_pending = 0;
    p = 0;
    send_frame(0, 0);
    drain();

    // Random data with gaps and a toggling sink.
    or_mode = 1;
    send_frame(1, 1);
    drain();

    check_eq("frame_done_count", fd_count, 8);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
